// File: rtl/edsac_pkg.sv
// Shared EDSAC serial-datapath constants, minor-cycle position type and transmitter states.
package edsac_pkg;

  localparam int MINOR_LEN  = 18;
  localparam int SHORT_BITS = 17;
  localparam int LONG_BITS  = MINOR_LEN + SHORT_BITS;
  localparam int POS_W      = 5;

  typedef logic [POS_W-1:0] pos_t;

  typedef enum logic [2:0] {
    IDLE,
    PEND,
    SHORT,
    LONG1,
    LONG2
  } tx_state_t;

endpackage

// File: rtl/digit_counter.sv
// Free-running mod-LEN digit position counter; pos_nxt_o exposes the value loaded on the next edge.
module digit_counter
  import edsac_pkg::*;
#(
  parameter int LEN = MINOR_LEN
) (
  input  logic clk,
  input  logic rst_n,
  output pos_t pos_o,
  output pos_t pos_nxt_o,
  output logic last_o
);

  pos_t cnt_q, cnt_d;

  always_comb begin
    last_o = (cnt_q == pos_t'(LEN - 1));
    cnt_d  = last_o ? '0 : cnt_q + pos_t'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign pos_o     = cnt_q;
  assign pos_nxt_o = cnt_d;

endmodule

// File: rtl/serial_word_tx.sv
// Parallel-to-serial EDSAC word transmitter: short/long words sent LSB-first on the minor-cycle frame.
// A word accepted mid-cycle waits in PEND; the next word can be taken at the gap digit of the last cycle.
module serial_word_tx
  import edsac_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_long,
  input  logic [LONG_BITS-1:0] din,
  output logic                 dout,
  output logic                 dout_valid,
  output logic                 word_end,
  output pos_t                 pos,
  output logic                 busy
);

  localparam pos_t LAST_DATA_POS = pos_t'(SHORT_BITS - 1);
  localparam logic [LONG_BITS-1:0] SHORT_MASK =
    {{(LONG_BITS - SHORT_BITS){1'b0}}, {SHORT_BITS{1'b1}}};

  tx_state_t            state_q, state_d;
  logic                 long_q, long_d;
  logic [LONG_BITS-1:0] sh_q, sh_d;
  logic                 dout_q, dout_d;
  logic                 dv_q, dv_d;
  logic                 we_q, we_d;

  pos_t                 pos_nxt;
  logic                 pos_last;
  logic                 accept;
  logic                 data_nxt;
  logic [LONG_BITS-1:0] src;

  digit_counter #(.LEN(MINOR_LEN)) u_digit_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .pos_o     (pos),
    .pos_nxt_o (pos_nxt),
    .last_o    (pos_last)
  );

  always_comb begin
    in_ready = (state_q == IDLE) ||
               (pos_last && (state_q == SHORT || state_q == LONG2));
    accept   = in_valid && in_ready;
    state_d  = state_q;
    long_d   = long_q;
    src      = sh_q;

    if (accept) begin
      long_d = in_long;
      src    = in_long ? din : (din & SHORT_MASK);
    end

    case (state_q)
      IDLE: begin
        if (accept) state_d = pos_last ? (in_long ? LONG1 : SHORT) : PEND;
      end
      PEND: begin
        if (pos_last) state_d = long_q ? LONG1 : SHORT;
      end
      SHORT, LONG2: begin
        if (pos_last) state_d = accept ? (in_long ? LONG1 : SHORT) : IDLE;
      end
      LONG1: begin
        if (pos_last) state_d = LONG2;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are derived from the state/position of the coming cycle.
    data_nxt = (state_d == LONG1) ||
               ((state_d == SHORT || state_d == LONG2) && (pos_nxt <= LAST_DATA_POS));
    sh_d     = data_nxt ? (src >> 1) : src;
    dout_d   = data_nxt && src[0];
    dv_d     = data_nxt;
    we_d     = (state_d == SHORT || state_d == LONG2) && (pos_nxt == LAST_DATA_POS);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      long_q  <= 1'b0;
      sh_q    <= '0;
      dout_q  <= 1'b0;
      dv_q    <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      long_q  <= long_d;
      sh_q    <= sh_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      we_q    <= we_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dv_q;
  assign word_end   = we_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_serial_word_tx.sv
// Directed bench for serial_word_tx: framing, latency, back-to-back, sandwich digit, hold and reset cases.
module tb_serial_word_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_long;
  logic [34:0] din;
  logic        dout;
  logic        dout_valid;
  logic        word_end;
  logic [4:0]  pos;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  serial_word_tx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_long    (in_long),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .word_end   (word_end),
    .pos        (pos),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_pos(input logic [4:0] target);
    int n = 0;
    while (pos !== target && n < 40) begin
      tick();
      n++;
    end
    if (pos !== target) chk("wait_pos", 64'(pos), 64'(target));
  endtask

  // Checks one whole minor cycle starting at pos 0; bit k of each vector is the value expected at pos k.
  task automatic check_minor(input string tag, input logic [17:0] exp_d,
                             input logic [17:0] exp_v, input logic [17:0] exp_we);
    for (int k = 0; k < 18; k++) begin
      chk($sformatf("%s_pos%0d", tag, k), 64'(pos), 64'(k));
      chk($sformatf("%s_dout%0d", tag, k), 64'(dout), 64'(exp_d[k]));
      chk($sformatf("%s_dv%0d", tag, k), 64'(dout_valid), 64'(exp_v[k]));
      chk($sformatf("%s_we%0d", tag, k), 64'(word_end), 64'(exp_we[k]));
      chk($sformatf("%s_busy%0d", tag, k), 64'(busy), 64'(1));
      tick();
    end
  endtask

  task automatic offer(input logic lng, input logic [34:0] w);
    in_valid = 1'b1;
    in_long  = lng;
    din      = w;
  endtask

  initial begin
    int n;
    logic [17:0] held_d;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_long  = 1'b0;
    din      = '0;
    repeat (3) tick();

    chk("rst_pos", 64'(pos), 64'(0));
    chk("rst_dout", 64'(dout), 64'(0));
    chk("rst_dv", 64'(dout_valid), 64'(0));
    chk("rst_we", 64'(word_end), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_rdy", 64'(in_ready), 64'(1));

    // Short word accepted at pos 0 waits out the cycle in PEND.
    rst_n = 1'b1;
    offer(1'b0, 35'h0_0001_5555);
    tick();
    in_valid = 1'b0;
    chk("pend_pos", 64'(pos), 64'(1));
    chk("pend_busy", 64'(busy), 64'(1));
    chk("pend_rdy", 64'(in_ready), 64'(0));
    n = 1;
    while (!dout_valid && n < 40) begin
      tick();
      n++;
    end
    chk("pend_latency", 64'(n), 64'(18));
    check_minor("short", 18'h15555, 18'h1FFFF, 18'h10000);
    chk("short_idle_busy", 64'(busy), 64'(0));
    chk("short_idle_dv", 64'(dout_valid), 64'(0));

    // Long word accepted at pos 17 starts on the very next digit.
    wait_pos(5'd17);
    offer(1'b1, 35'h4_0000_0001);
    chk("long_rdy17", 64'(in_ready), 64'(1));
    tick();
    in_valid = 1'b0;
    check_minor("long1", 18'h00001, 18'h3FFFF, 18'h00000);
    check_minor("long2", 18'h10000, 18'h1FFFF, 18'h10000);

    // Back-to-back short words: second one taken at the gap digit of the first.
    wait_pos(5'd17);
    offer(1'b0, 35'h0_0001_FFFF);
    tick();
    din = 35'h0_0000_0001;
    check_minor("b2b_1", 18'h1FFFF, 18'h1FFFF, 18'h10000);
    in_valid = 1'b0;
    check_minor("b2b_2", 18'h00001, 18'h1FFFF, 18'h10000);
    chk("b2b_idle_busy", 64'(busy), 64'(0));

    // Sandwich digit of a long word is a real data digit.
    wait_pos(5'd17);
    offer(1'b1, 35'h0_0002_0000);
    tick();
    in_valid = 1'b0;
    check_minor("sand1", 18'h20000, 18'h3FFFF, 18'h00000);
    check_minor("sand2", 18'h00000, 18'h1FFFF, 18'h10000);

    // Valid held while not ready with a changing din: only the pos-17 value is captured.
    wait_pos(5'd17);
    offer(1'b0, 35'h0_0000_A5C3);
    tick();
    held_d = 18'h0A5C3;
    for (int k = 0; k < 18; k++) begin
      chk($sformatf("hold_rdy%0d", k), 64'(in_ready), 64'(k == 17));
      chk($sformatf("hold_dout%0d", k), 64'(dout), 64'(held_d[k]));
      if (k == 17) din = {18'h3FFFF, 17'h12345};
      else         din = {$urandom_range(7, 0), $urandom()};
      tick();
    end
    in_valid = 1'b0;
    check_minor("hold2", 18'h12345, 18'h1FFFF, 18'h10000);

    // Reset in the middle of a long word abandons it.
    wait_pos(5'd17);
    offer(1'b1, 35'h7_FFFF_FFFF);
    tick();
    in_valid = 1'b0;
    repeat (8) tick();
    chk("mid_pos", 64'(pos), 64'(8));
    chk("mid_dout", 64'(dout), 64'(1));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_pos", 64'(pos), 64'(0));
    chk("mrst_dout", 64'(dout), 64'(0));
    chk("mrst_dv", 64'(dout_valid), 64'(0));
    chk("mrst_busy", 64'(busy), 64'(0));
    chk("mrst_rdy", 64'(in_ready), 64'(1));
    for (int k = 0; k < 40; k++) begin
      chk($sformatf("mrst_we%0d", k), 64'(word_end), 64'(0));
      chk($sformatf("mrst_dv%0d", k), 64'(dout_valid), 64'(0));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
